// File: rtl/iob_ddr_arbiter_pkg.sv
// Shared types and AXI constants for the two-master DDR arbiter.
// State encodings, fixed single-beat burst attributes and the OKAY response code.
package iob_ddr_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWaddr = 3'd1,
    StRaddr = 3'd2,
    StWresp = 3'd3,
    StRdata = 3'd4,
    StDone  = 3'd5
  } state_e;

  localparam logic [7:0] AxiLen       = 8'd0;
  localparam logic [2:0] AxiSize      = 3'd2;
  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [3:0] AxiCache     = 4'b0011;
  localparam logic [1:0] AxiRespOkay  = 2'b00;

endpackage

// File: rtl/iob_ddr_arbiter_if.sv
// AXI4 bus between the arbiter (master) and the DDR memory (slave).
// Carries only the channels a single-beat master needs; no wlast.
interface iob_ddr_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 1
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/iob_ddr_arb_sel.sv
// Grant picker for two requesters. IOB_DDR_ARB_RR_EN selects round-robin with a
// last-grant register; otherwise fixed priority (m1 over m0) and no state.
module iob_ddr_arb_sel (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       idle,
  output logic       grant,
  output logic       grant_valid
);

  assign grant_valid = idle & (|valid);

`ifdef IOB_DDR_ARB_RR_EN
  logic last_q;

  // Reset to 1 so m0 wins the first contest.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (grant_valid) begin
      last_q <= grant;
    end
  end

  always_comb begin
    grant = valid[1];
    if (&valid) begin
      grant = ~last_q;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;

  assign grant = valid[1];
`endif

endmodule

// File: rtl/iob_ddr_arbiter.sv
// Two-master native-bus to single-beat AXI4 bridge, one transaction outstanding.
// Define IOB_DDR_ARB_RR_EN for round-robin arbitration instead of m1-first priority.
module iob_ddr_arbiter
  import iob_ddr_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned AXI_ID_W = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  output logic                err,
  iob_ddr_arbiter_if.master   m_axi
);

  state_e              state_q, state_d;
  logic                aw_pend_q, aw_pend_d;
  logic                w_pend_q, w_pend_d;
  logic                err_q, err_d;
  logic                grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;
  logic                is_idle, sel_grant, sel_valid;
  logic [DATA_W/8-1:0] req_wstrb;
  logic                unused_rlast;

  assign is_idle      = (state_q == StIdle);
  assign req_wstrb    = sel_grant ? m1_wstrb : m0_wstrb;
  assign unused_rlast = m_axi.rlast;

  iob_ddr_arb_sel u_sel (
    .clk         (clk),
    .reset       (reset),
    .valid       ({m1_valid, m0_valid}),
    .idle        (is_idle),
    .grant       (sel_grant),
    .grant_valid (sel_valid)
  );

  always_comb begin
    state_d   = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          state_d   = (req_wstrb != '0) ? StWaddr : StRaddr;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
        end
      end
      StWaddr: begin
        // Address and data handshake independently; move on once both are done.
        if (m_axi.awready) aw_pend_d = 1'b0;
        if (m_axi.wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = StWresp;
      end
      StWresp: begin
        if (m_axi.bvalid) begin
          state_d = StDone;
          if (m_axi.bresp != AxiRespOkay) err_d = 1'b1;
        end
      end
      StRaddr: begin
        if (m_axi.arready) state_d = StRdata;
      end
      StRdata: begin
        if (m_axi.rvalid) begin
          state_d = StDone;
          if (m_axi.rresp != AxiRespOkay) err_d = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      err_q      <= 1'b0;
      grant_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      err_q     <= err_d;
      if (sel_valid) begin
        grant_q <= sel_grant;
        addr_q  <= sel_grant ? m1_addr : m0_addr;
        wdata_q <= sel_grant ? m1_wdata : m0_wdata;
        wstrb_q <= req_wstrb;
      end
      if (state_q == StRdata && m_axi.rvalid) begin
        if (grant_q) m1_rdata_q <= m_axi.rdata;
        else         m0_rdata_q <= m_axi.rdata;
      end
    end
  end

  assign m0_ready = (state_q == StDone) && !grant_q;
  assign m1_ready = (state_q == StDone) && grant_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign err      = err_q;

  assign m_axi.awid    = AXI_ID_W'(grant_q);
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = AxiLen;
  assign m_axi.awsize  = AxiSize;
  assign m_axi.awburst = AxiBurstIncr;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = AxiCache;
  assign m_axi.awprot  = '0;
  assign m_axi.awqos   = '0;
  assign m_axi.awvalid = (state_q == StWaddr) && aw_pend_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = (state_q == StWaddr) && w_pend_q;
  assign m_axi.bready  = (state_q == StWresp);
  assign m_axi.arid    = AXI_ID_W'(grant_q);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = AxiLen;
  assign m_axi.arsize  = AxiSize;
  assign m_axi.arburst = AxiBurstIncr;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = AxiCache;
  assign m_axi.arprot  = '0;
  assign m_axi.arqos   = '0;
  assign m_axi.arvalid = (state_q == StRaddr);
  assign m_axi.rready  = (state_q == StRdata);

endmodule
